// File: rtl/motor_pkg.sv
// Shared types and constants for the motor PWM driver.
//   state_e     : driver FSM states
//   motor_cmd_t : {dir, duty[7:0]} view of the 9-bit command bus
package motor_pkg;

  localparam int unsigned CMD_W   = 9;
  localparam int unsigned DIR_BIT = 8;
  localparam int unsigned DUTY_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD
  } state_e;

  typedef struct packed {
    logic              dir;
    logic [DUTY_W-1:0] duty;
  } motor_cmd_t;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: a 0..CLK_DIV-1 prescaler feeding an 8-bit wrapping PWM counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : force prescaler and counter to zero
//   run          : advance the timebase (held at zero while low)
//   pwm_cnt      : current PWM count, 0..255
//   tick         : last prescaler cycle of the current count step
//   wrap         : tick while pwm_cnt is 255 (last cycle of the PWM period)
module pwm_timebase
  import motor_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              run,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              tick,
  output logic              wrap
);

  localparam int unsigned       PrescW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_DIV - 1);

  logic [PrescW-1:0] presc;

  // Gated by run so CLK_DIV=1 cannot produce ticks while the prescaler is parked.
  assign tick = run & (presc == PrescMax);
  assign wrap = tick & (pwm_cnt == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (clear || !run) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      if (tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        presc   <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: decodes the {dir, duty} motor command into a 256-step PWM
// and H-bridge direction pins, inserting a bridge-off dead time on reversals.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : driver enable; low forces the bridge off
//   cmd          : [8] dir (0 fwd, 1 rev), [7:0] duty
//   pwm          : registered PWM to the bridge enable
//   in1, in2     : registered bridge inputs (never both high)
//   busy         : high while in dead time
//   period_start : one-clk pulse at each PWM period wrap while running
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 10,
  parameter int unsigned DEAD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CMD_W-1:0] cmd,
  output logic             pwm,
  output logic             in1,
  output logic             in2,
  output logic             busy,
  output logic             period_start
);

  localparam int unsigned      DeadW    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DeadW-1:0] DeadLast = DeadW'(DEAD_CYCLES - 1);

  motor_cmd_t        cmd_s;
  state_e            state;
  logic              dir_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DeadW-1:0]  dead_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              wrap;
  logic              unused_tick;
  logic              tb_run;

  assign cmd_s  = motor_cmd_t'(cmd);
  assign tb_run = (state == RUN);

  // Counters park at zero outside RUN, so every RUN entry starts a fresh period.
  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!tb_run),
    .run     (tb_run),
    .pwm_cnt (pwm_cnt),
    .tick    (unused_tick),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dir_q        <= 1'b0;
      duty_q       <= '0;
      dead_cnt     <= '0;
      pwm          <= 1'b0;
      in1          <= 1'b0;
      in2          <= 1'b0;
      busy         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      // Outputs follow the current state one clock later; in1/in2 are decoded
      // from a single dir bit so they can never both be high.
      pwm          <= (state == RUN) && (pwm_cnt < duty_q);
      in1          <= (state == RUN) && !dir_q;
      in2          <= (state == RUN) && dir_q;
      busy         <= (state == DEAD);
      period_start <= (state == RUN) && wrap;

      unique case (state)
        IDLE: begin
          if (enable) begin
            state  <= RUN;
            dir_q  <= cmd_s.dir;
            duty_q <= cmd_s.duty;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cmd_s.dir != dir_q) begin
            state    <= DEAD;
            dead_cnt <= '0;
          end else if (wrap) begin
            // Duty only changes at the period boundary: no runt pulses.
            duty_q <= cmd_s.duty;
          end
        end
        DEAD: begin
          if (!enable) begin
            state <= IDLE;
          end else if (dead_cnt == DeadLast) begin
            // Direction is re-sampled here, so a flip-back mid-dead-time
            // simply resumes in whatever direction cmd now shows.
            state  <= RUN;
            dir_q  <= cmd_s.dir;
            duty_q <= cmd_s.duty;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with CLK_DIV=2, DEAD_CYCLES=8.
module tb_motor_pwm_driver;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned DEAD_CYCLES = 8;
  localparam int          PERIOD      = 256 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [8:0] cmd = 9'h000;
  logic       pwm, in1, in2, busy, period_start;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;

  motor_pwm_driver #(
    .CLK_DIV     (CLK_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cmd          (cmd),
    .pwm          (pwm),
    .in1          (in1),
    .in2          (in2),
    .busy         (busy),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (in1 === 1'b1 && in2 === 1'b1) overlap++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the first sample showing period_start (possibly the current one).
  task automatic wait_start(input string tag);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (period_start === 1'b1) break;
      step();
    end
    check(tag, {31'b0, period_start}, 32'd1);
  endtask

  // Samples one full PWM period; optionally changes cmd at sample chg_at.
  task automatic measure(input int chg_at, input logic [8:0] chg_cmd,
                         output int high, output int rises, output int starts);
    logic prev;
    prev   = pwm;
    high   = 0;
    rises  = 0;
    starts = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k == chg_at) cmd = chg_cmd;
      step();
      if (pwm === 1'b1) high++;
      if (pwm === 1'b1 && prev === 1'b0) rises++;
      if (period_start === 1'b1) starts++;
      prev = pwm;
    end
  endtask

  initial begin
    int   high, rises, starts, total, len, bad, guard;
    logic prev_in1;

    // Reset held with enable and a command present.
    reset_n = 1'b0;
    enable  = 1'b1;
    cmd     = 9'h0FF;
    repeat (3) step();
    check("rst_pwm", {31'b0, pwm}, 32'd0);
    check("rst_in1", {31'b0, in1}, 32'd0);
    check("rst_in2", {31'b0, in2}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_period_start", {31'b0, period_start}, 32'd0);

    // First edge enters RUN; outputs reflect it one clock later.
    reset_n = 1'b1;
    step();
    check("entry_in1_lag", {31'b0, in1}, 32'd0);
    step();
    check("entry_in1", {31'b0, in1}, 32'd1);
    check("entry_in2", {31'b0, in2}, 32'd0);

    // Duty 0x40: 128 of 512 clk high, one period_start per period.
    cmd = 9'h040;
    wait_start("ps_first");
    measure(-1, 9'h000, high, rises, starts);
    check("d40_high", high, 32'd128);
    check("d40_starts", starts, 32'd1);
    check("d40_rises", rises, 32'd1);

    // Mid-period change to 0xC0 near count 10: current period unchanged.
    wait_start("ps_mid");
    measure(20, 9'h0C0, high, rises, starts);
    check("mid_keep_high", high, 32'd128);
    check("mid_keep_rises", rises, 32'd1);
    wait_start("ps_c0");
    measure(-1, 9'h000, high, rises, starts);
    check("dc0_high", high, 32'd384);
    check("dc0_rises", rises, 32'd1);

    // Duty 0xFF: low exactly CLK_DIV clk per period.
    cmd = 9'h0FF;
    wait_start("ps_ff_a");
    measure(-1, 9'h000, high, rises, starts);
    check("ff_pending_high", high, 32'd384);
    wait_start("ps_ff_b");
    measure(-1, 9'h000, high, rises, starts);
    check("dff_low", PERIOD - high, CLK_DIV);
    check("dff_rises", rises, 32'd1);

    // Duty 0: never high over three periods.
    cmd = 9'h000;
    wait_start("ps_zero_a");
    measure(-1, 9'h000, high, rises, starts);
    total = 0;
    for (int p = 0; p < 3; p++) begin
      wait_start("ps_zero_b");
      measure(-1, 9'h000, high, rises, starts);
      total += high;
    end
    check("d00_high", total, 32'd0);

    // Forward at duty 0x80, then reverse.
    cmd = 9'h080;
    wait_start("ps_80_a");
    measure(-1, 9'h000, high, rises, starts);
    wait_start("ps_80_b");
    measure(-1, 9'h000, high, rises, starts);
    check("d80_high", high, 32'd256);
    repeat (30) step();
    cmd      = 9'h180;
    guard    = 0;
    prev_in1 = in1;
    step();
    while (busy !== 1'b1 && guard < 20) begin
      prev_in1 = in1;
      step();
      guard++;
    end
    check("rev_busy_seen", {31'b0, busy}, 32'd1);
    check("rev_old_dir_before", {31'b0, prev_in1}, 32'd1);
    len = 0;
    bad = 0;
    while (busy === 1'b1 && len < 40) begin
      len++;
      if (pwm !== 1'b0 || in1 !== 1'b0 || in2 !== 1'b0) bad++;
      step();
    end
    check("rev_dead_len", len, DEAD_CYCLES);
    check("rev_bridge_off", bad, 32'd0);
    check("rev_in2", {31'b0, in2}, 32'd1);
    check("rev_in1", {31'b0, in1}, 32'd0);

    // Abort dead time by dropping enable.
    cmd   = 9'h080;
    guard = 0;
    while (busy !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    check("abort_busy_seen", {31'b0, busy}, 32'd1);
    repeat (3) step();
    enable = 1'b0;
    step();
    step();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_pwm", {31'b0, pwm}, 32'd0);
    check("abort_in1", {31'b0, in1}, 32'd0);
    check("abort_in2", {31'b0, in2}, 32'd0);
    repeat (DEAD_CYCLES + 4) step();
    check("abort_stays_idle", {31'b0, busy | in1 | in2}, 32'd0);

    // Asynchronous reset in the middle of RUN.
    enable = 1'b1;
    guard  = 0;
    while (pwm !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    check("run_pwm_high", {31'b0, pwm}, 32'd1);
    check("run_in1_high", {31'b0, in1}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pwm", {31'b0, pwm}, 32'd0);
    check("arst_in1", {31'b0, in1}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("post_rst_idle", {31'b0, in1 | in2 | pwm}, 32'd0);
    enable = 1'b1;
    step();
    step();
    check("post_rst_run_in1", {31'b0, in1}, 32'd1);

    check("in1_in2_overlap", overlap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
